reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Debug reader for the 16x8 register file. On a start pulse it walks the read
//  port (address, data) from index 0 up to NUM_REGS-1. It streams a framed dump
//  on a valid/ready byte interface: header, NUM_REGS data bytes, XOR checksum.
//  Sits beside the core and shares a read port with it; feeds a UART/debug TX.
// PARAMETERS
//  NUM_REGS  16    registers dumped per frame (power of two, <= 2**ADDR_W)
//  ADDR_W    4     register index width
//  DATA_W    8     register/byte width
//  HDR_BYTE  8'hA5 frame header value
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       request a dump; sampled only in IDLE
//  rd_addr    out  ADDR_W  register file read address
//  rd_data    in   DATA_W  register file read data (combinational from rd_addr)
//  out_data   out  DATA_W  stream byte
//  out_valid  out  1       stream byte valid
//  out_ready  in   1       downstream accepts byte
//  busy       out  1       frame in progress
//  done       out  1       one-cycle pulse: checksum byte accepted
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE. out_valid=0, out_data=0.
//   rd_addr=0, busy=0, done=0, idx=0, csum=0.
//  Handshake: byte transfers on a clk edge with out_valid&&out_ready.
//   Once out_valid=1, out_data is held stable and out_valid stays 1 until the
//   transfer. out_valid never depends combinationally on out_ready.
//  States:
//   IDLE : start=1 -> HDR. Load out_data=HDR_BYTE, out_valid=1, busy=1,
//          idx=0, csum=0.
//   HDR  : on transfer -> FETCH, out_valid=0.
//   FETCH: rd_addr=idx. Capture out_data<=rd_data, out_valid<=1 -> DATA.
//          One bubble cycle per byte.
//   DATA : on transfer csum<=csum^out_data, out_valid<=0.
//          If idx==NUM_REGS-1, load checksum byte (csum^out_data),
//          out_valid<=1 -> CSUM. Otherwise idx<=idx+1 -> FETCH.
//   CSUM : on transfer -> IDLE, out_valid<=0, busy<=0, done<=1 for that 1 cycle.
//  Latency: start at edge T -> header valid after T. With out_ready held 1,
//   the frame is 1 + 2*NUM_REGS + 1 transfers/cycles. done follows the last
//   transfer edge.
//  rd_addr is driven to idx in all states (0 when idle).
//  Checksum = XOR of the NUM_REGS data bytes only (header excluded), DATA_W wide.
//  Boundaries:
//   - start while busy: ignored, no queuing.
//   - start on the same edge that done is set: ignored (state is CSUM at sample).
//   - out_ready stuck low: stall indefinitely, no timeout, outputs held.
//   - register writes during a dump: each byte reflects rd_data in its FETCH
//     cycle. There is no frame atomicity.
//   - idx wraps only through the DATA->CSUM exit; never indexes >= NUM_REGS.
//   - rst_n low mid-frame: immediate return to reset values, the partial frame
//     is abandoned, and no done is issued.
// STRUCTURE
//  Shared package (cpu_pkg): REG_ADDR_W=4, REG_DATA_W=8, NUM_REGS=16,
//   DUMP_HDR=8'hA5, state encoding localparams
//   (IDLE, HDR, FETCH, DATA, CSUM).
//  Single module; no sub-module. The FSM, index counter, checksum register and
//   output byte register live in one clocked always block plus rd_addr assign.
// TESTING (bench models the register file; scoreboard checks bytes)
//  1. All regs 0, out_ready=1, start pulse -> A5, 16x00, 00; done 1 cycle; 34 cycles.
//  2. reg[i]=i+1 -> A5,01..10 in order, checksum 8'h10; busy falls with done.
//  3. out_ready random 30% -> same byte sequence as test 2.
//     out_data/out_valid are stable across every stalled cycle.
//  4. start held high for whole frame and re-pulsed mid-frame -> one frame only.
//     A new frame starts only on a start seen in IDLE after done.
//  5. Write reg[5]=8'h3C just before its FETCH, reg[2]=8'hFF after its DATA
//     transfer -> byte5=3C, byte2 is the old value, checksum matches emitted bytes.
//  6. rst_n low mid-DATA for 3 cycles -> out_valid/busy/done drop asynchronously.
//     The next start yields a complete correct frame.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants: register file geometry, dump framing
// and the register-dump reader state encoding.
package cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 8;
    localparam int NUM_REGS   = 16;

    localparam logic [REG_DATA_W-1:0] DUMP_HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Register file dump reader: walks the read port and streams
// header, NUM_REGS data bytes and an XOR checksum.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start              request a dump (sampled in IDLE)
//   rd_addr / rd_data  register file read port
//   out_data/out_valid/out_ready  byte stream
//   busy               frame in progress
//   done               1-cycle pulse after checksum accepted
module reg_dump_reader
    import cpu_pkg::*;
#(
    parameter int              NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int              ADDR_W   = REG_ADDR_W,
    parameter int              DATA_W   = REG_DATA_W,
    parameter logic [DATA_W-1:0] HDR_BYTE = DUMP_HDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [DATA_W-1:0] csum, csum_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              busy_n;
    logic              done_n;
    logic              xfer;

    assign xfer    = out_valid & out_ready;
    assign rd_addr = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            csum      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            csum      <= csum_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        csum_n  = csum;
        data_n  = out_data;
        valid_n = out_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = HDR;
                    data_n  = HDR_BYTE;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    idx_n   = '0;
                    csum_n  = '0;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_n = FETCH;
                    valid_n = 1'b0;
                end
            end
            FETCH: begin
                data_n  = rd_data;
                valid_n = 1'b1;
                state_n = DATA;
            end
            DATA: begin
                if (xfer) begin
                    csum_n  = csum ^ out_data;
                    valid_n = 1'b0;
                    if (idx == LAST) begin
                        // idx wraps here so IDLE shows address 0
                        idx_n   = '0;
                        data_n  = csum ^ out_data;
                        valid_n = 1'b1;
                        state_n = CSUM;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: frame-level model
// with a per-cycle compare process.
module tb_reg_dump_reader;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       done;

    logic [7:0] regs [16];
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    reg_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q [$];
    bit         active = 1'b0;
    bit         done_exp = 1'b0;
    int         frames = 0;
    int         xfer_cnt = 0;
    bit         ov_en [16];
    logic [7:0] ov_val [16];
    bit         rand_ready = 1'b0;

    // byte k of the frame the model expects right now
    function automatic logic [7:0] model_byte(input int k);
        logic [7:0] c;
        c = 8'h00;
        if (k == 0) return 8'hA5;
        if (k <= 16) return ov_en[k-1] ? ov_val[k-1] : regs[k-1];
        for (int i = 1; i <= 16; i++) c ^= model_byte(i);
        return c;
    endfunction

    function automatic void build_frame();
        exp_q.delete();
        for (int k = 0; k < 18; k++) exp_q.push_back(model_byte(k));
        frames++;
        xfer_cnt = 0;
    endfunction

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(negedge clk) begin
        logic [7:0] b;
        if (!rst_n) begin
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_busy",  32'(busy),      32'd0);
            chk("rst_done",  32'(done),      32'd0);
            chk("rst_addr",  32'(rd_addr),   32'd0);
            chk("rst_data",  32'(out_data),  32'd0);
            exp_q.delete();
            active   = 1'b0;
            done_exp = 1'b0;
            pv       = 1'b0;
        end else begin
            chk("done", 32'(done), 32'(done_exp));
            chk("busy", 32'(busy), 32'(active));
            if (!active) begin
                chk("idle_valid", 32'(out_valid), 32'd0);
                chk("idle_addr",  32'(rd_addr),   32'd0);
            end
            if (pv && !pr) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data",  32'(out_data),  32'(pd));
            end
            done_exp = 1'b0;
            if (active && out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_byte: got %0h expected none",
                             out_data);
                end else begin
                    b = exp_q.pop_front();
                    chk("byte", 32'(out_data), 32'(b));
                    if (exp_q.size() == 0) begin
                        done_exp = 1'b1;
                        active   = 1'b0;
                    end
                end
            end else if (!active && start) begin
                build_frame();
                active = 1'b1;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (rand_ready) out_ready = ($urandom_range(0, 99) >= 30);
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while ((active || busy) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_chk++;
        if (n >= max) begin
            n_fail++;
            $display("FAIL wait_done: got timeout after %0d cycles", n);
        end
    endtask

    task automatic wait_xfer(input int cnt);
        int n;
        n = 0;
        while (xfer_cnt < cnt && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_chk++;
        if (n >= 500) begin
            n_fail++;
            $display("FAIL wait_xfer: got %0d expected %0d", xfer_cnt, cnt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int f0;
        for (int i = 0; i < 16; i++) begin
            regs[i]   = 8'h00;
            ov_en[i]  = 1'b0;
            ov_val[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: all zero, 34-cycle frame
        chk("t1_model_csum", 32'(model_byte(17)), 32'h00);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t1_cycles", 32'(cyc), 32'd34);
        repeat (3) @(posedge clk);
        #1;

        // 2: incrementing pattern
        for (int i = 0; i < 16; i++) regs[i] = 8'(i + 1);
        chk("t2_model_hdr",  32'(model_byte(0)),  32'hA5);
        chk("t2_model_b5",   32'(model_byte(5)),  32'h05);
        chk("t2_model_csum", 32'(model_byte(17)), 32'h10);
        pulse_start();
        wait_done(100);
        repeat (2) @(posedge clk);
        #1;

        // 3: random backpressure
        rand_ready = 1'b1;
        pulse_start();
        wait_done(2000);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 4: start held and re-pulsed during the frame
        f0 = frames;
        start = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 10) start = 1'b0;
            if (cyc == 11) start = 1'b1;
            if (done) break;
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_frames", 32'(frames - f0), 32'd1);
        chk("t4_idle",   32'(busy),        32'd0);

        // 5: writes during the dump
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
        regs[5]   = 8'h11;
        ov_en[5]  = 1'b1;
        ov_val[5] = 8'h3C;
        pulse_start();
        wait_xfer(4);
        regs[2] = 8'hFF;
        wait_xfer(6);
        regs[5] = 8'h3C;
        wait_done(100);
        ov_en[5] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 6: reset mid-frame, then a clean frame
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
        pulse_start();
        wait_xfer(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_done",  32'(done),      32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        wait_done(100);
        repeat (3) @(posedge clk);
        #1;
        chk("end_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
